// File: rtl/memory_controller.sv
// Address decoder and bus router from the core data bus to code, data, input and output targets.
// Optional MEMCTRL_FAULT_ADDR_EN adds a fault_address capture register.
module memory_controller #(
   parameter logic [31:0] CODE_BASE = 32'h0000_0000,
   parameter logic [31:0] CODE_SIZE = 32'h0001_0000,
   parameter logic [31:0] MEM_BASE  = 32'h1000_0000,
   parameter logic [31:0] MEM_SIZE  = 32'h0010_0000,
   parameter logic [31:0] IN_BASE   = 32'h2000_0000,
   parameter logic [31:0] IN_SIZE   = 32'h0000_0010,
   parameter logic [31:0] OUT_BASE  = 32'h3000_0000,
   parameter logic [31:0] OUT_SIZE  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic        write_enable,
   input  logic [1:0]  data_in_size,
   input  logic [1:0]  data_out_size,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        memory_error,
   input  logic [31:0] code_in,
   output logic [31:0] code_address,
   input  logic [31:0] memory_in,
   output logic [31:0] memory_address,
   output logic [31:0] memory_out,
   output logic [1:0]  memory_size,
   output logic        memory_write_enable,
   input  logic [31:0] input_in,
   input  logic [31:0] output_in,
   output logic [31:0] output_address,
   output logic [31:0] output_out,
   output logic [1:0]  output_size,
   output logic        output_write_enable
`ifdef MEMCTRL_FAULT_ADDR_EN
   ,
   output logic [31:0] fault_address
`endif
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   logic [1:0]  size;
   logic [31:0] code_off;
   logic [31:0] mem_off;
   logic [31:0] in_off;
   logic [31:0] out_off;
   logic        code_hit;
   logic        mem_hit;
   logic        in_hit;
   logic        out_hit;
   logic        fault;
   logic [31:0] read_sel;
   logic [31:0] read_mask;

   assign size = write_enable ? data_in_size : data_out_size;

   // Regions never wrap past 2^32, so a single unsigned offset compare
   // covers both the lower and upper bound.
   assign code_off = address - CODE_BASE;
   assign mem_off  = address - MEM_BASE;
   assign in_off   = address - IN_BASE;
   assign out_off  = address - OUT_BASE;

   assign code_hit = code_off < CODE_SIZE;
   assign mem_hit  = mem_off < MEM_SIZE;
   assign in_hit   = in_off < IN_SIZE;
   assign out_hit  = out_off < OUT_SIZE;

   assign code_address   = code_off;
   assign memory_address = mem_off;
   assign output_address = out_off;

   assign memory_out  = data_in;
   assign output_out  = data_in;
   assign memory_size = size;
   assign output_size = size;

   always_comb begin
      fault = 1'b0;
      if (!(code_hit || mem_hit || in_hit || out_hit)) fault = 1'b1;
      if (size == SZ_RSVD) fault = 1'b1;
      if (size == SZ_HALF && address[0]) fault = 1'b1;
      if (size == SZ_WORD && address[1:0] != 2'b00) fault = 1'b1;
      if (write_enable && (code_hit || in_hit)) fault = 1'b1;
   end

   assign memory_write_enable = rst & write_enable & mem_hit & ~fault;
   assign output_write_enable = rst & write_enable & out_hit & ~fault;

   always_comb begin
      read_sel = 32'h0;
      unique case (1'b1)
         code_hit: read_sel = code_in;
         mem_hit:  read_sel = memory_in;
         in_hit:   read_sel = input_in;
         out_hit:  read_sel = output_in;
         default:  read_sel = 32'h0;
      endcase
   end

   always_comb begin
      read_mask = 32'hFFFF_FFFF;
      case (data_out_size)
         SZ_BYTE: read_mask = 32'h0000_00FF;
         SZ_HALF: read_mask = 32'h0000_FFFF;
         default: read_mask = 32'hFFFF_FFFF;
      endcase
   end

   assign data_out = fault ? 32'h0 : (read_sel & read_mask);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) memory_error <= 1'b0;
      else if (fault) memory_error <= 1'b1;
   end

`ifdef MEMCTRL_FAULT_ADDR_EN
   // Captures only the address of the fault that first raised the flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fault_address <= 32'h0;
      else if (fault && !memory_error) fault_address <= address;
   end
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Randomized self-checking bench for memory_controller against a region-table model.
// Directed literal checks pin the model; MEMCTRL_FAULT_ADDR_EN enables fault_address checks.
module tb_memory_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic        write_enable;
   logic [1:0]  data_in_size;
   logic [1:0]  data_out_size;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        memory_error;
   logic [31:0] code_in;
   logic [31:0] code_address;
   logic [31:0] memory_in;
   logic [31:0] memory_address;
   logic [31:0] memory_out;
   logic [1:0]  memory_size;
   logic        memory_write_enable;
   logic [31:0] input_in;
   logic [31:0] output_in;
   logic [31:0] output_address;
   logic [31:0] output_out;
   logic [1:0]  output_size;
   logic        output_write_enable;
`ifdef MEMCTRL_FAULT_ADDR_EN
   logic [31:0] fault_address;
`endif

   memory_controller dut (
      .clk                 (clk),
      .rst                 (rst),
      .address             (address),
      .write_enable        (write_enable),
      .data_in_size        (data_in_size),
      .data_out_size       (data_out_size),
      .data_in             (data_in),
      .data_out            (data_out),
      .memory_error        (memory_error),
      .code_in             (code_in),
      .code_address        (code_address),
      .memory_in           (memory_in),
      .memory_address      (memory_address),
      .memory_out          (memory_out),
      .memory_size         (memory_size),
      .memory_write_enable (memory_write_enable),
      .input_in            (input_in),
      .output_in           (output_in),
      .output_address      (output_address),
      .output_out          (output_out),
      .output_size         (output_size),
      .output_write_enable (output_write_enable)
`ifdef MEMCTRL_FAULT_ADDR_EN
      ,
      .fault_address       (fault_address)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   logic        exp_err;
   logic [31:0] exp_fa;

   longint unsigned reg_base [4] = '{64'h0000_0000, 64'h1000_0000,
                                     64'h2000_0000, 64'h3000_0000};
   longint unsigned reg_size [4] = '{64'h0001_0000, 64'h0010_0000,
                                     64'h0000_0010, 64'h0000_0100};

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
      end
   endtask

   // Region index 0=code 1=mem 2=in 3=out, -1 when unmapped.
   function automatic int region(input logic [31:0] a);
      longint unsigned la;
      la = 64'(a);
      for (int i = 0; i < 4; i++)
         if (la >= reg_base[i] && la < reg_base[i] + reg_size[i]) return i;
      return -1;
   endfunction

   function automatic logic [1:0] cur_size();
      return write_enable ? data_in_size : data_out_size;
   endfunction

   function automatic logic model_fault();
      int r;
      int s;
      r = region(address);
      s = int'(cur_size());
      if (r < 0) return 1'b1;
      if (s == 3) return 1'b1;
      if (s == 1 && (address % 2) != 0) return 1'b1;
      if (s == 2 && (address % 4) != 0) return 1'b1;
      if (write_enable && (r == 0 || r == 2)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all();
      int          r;
      logic        f;
      logic [31:0] sel;
      logic [31:0] val;
      r = region(address);
      f = model_fault();
      case (r)
         0: sel = code_in;
         1: sel = memory_in;
         2: sel = input_in;
         3: sel = output_in;
         default: sel = 32'h0;
      endcase
      case (data_out_size)
         2'd0: val = sel % 32'h100;
         2'd1: val = sel % 32'h1_0000;
         default: val = sel;
      endcase
      chk("data_out", data_out, f ? 32'h0 : val);
      chk("code_address", code_address, address - 32'h0000_0000);
      chk("memory_address", memory_address, address - 32'h1000_0000);
      chk("output_address", output_address, address - 32'h3000_0000);
      chk("memory_out", memory_out, data_in);
      chk("output_out", output_out, data_in);
      chk("memory_size", 32'(memory_size), 32'(cur_size()));
      chk("output_size", 32'(output_size), 32'(cur_size()));
      chk("memory_we", 32'(memory_write_enable),
          32'(rst && write_enable && r == 1 && !f));
      chk("output_we", 32'(output_write_enable),
          32'(rst && write_enable && r == 3 && !f));
      chk("memory_error", 32'(memory_error), 32'(exp_err));
`ifdef MEMCTRL_FAULT_ADDR_EN
      chk("fault_address", fault_address, exp_fa);
`endif
   endtask

   // Check at the falling edge, then advance the sticky-flag model
   // across the rising edge; returns 1ns after it.
   task automatic step();
      logic f;
      @(negedge clk);
      check_all();
      f = model_fault();
      @(posedge clk);
      if (rst && f && !exp_err) begin
         exp_err = 1'b1;
         exp_fa = address;
      end
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic we,
                        input logic [1:0] isz, input logic [1:0] osz,
                        input logic [31:0] din);
      address = a;
      write_enable = we;
      data_in_size = isz;
      data_out_size = osz;
      data_in = din;
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (!v) begin
         exp_err = 1'b0;
         exp_fa = 32'h0;
      end
   endtask

   task automatic pulse_rst();
      set_rst(1'b0);
      #1;
      chk("async_rst_err", 32'(memory_error), 32'h0);
      set_rst(1'b1);
   endtask

   int          rsel;
   logic [31:0] a;

   initial begin
      exp_err = 1'b0;
      exp_fa = 32'h0;
      code_in = 32'h0;
      memory_in = 32'h0;
      input_in = 32'h0;
      output_in = 32'h0;
      set_rst(1'b0);
      drive(32'h1000_0000, 1'b1, 2'd2, 2'd2, 32'hCAFE_F00D);
      step();
      chk("lit_rst_err", 32'(memory_error), 32'h0);
      chk("lit_rst_mwe", 32'(memory_write_enable), 32'h0);
      chk("lit_rst_owe", 32'(output_write_enable), 32'h0);
      set_rst(1'b1);

      code_in = 32'hDEAD_BEEF;
      drive(32'h0000_0004, 1'b0, 2'd0, 2'd2, 32'h0);
      step();
      chk("lit_code_rd", data_out, 32'hDEAD_BEEF);
      chk("lit_code_addr", code_address, 32'h4);
      chk("lit_code_err", 32'(memory_error), 32'h0);

      drive(32'h1000_0010, 1'b1, 2'd2, 2'd0, 32'h1234_5678);
      step();
      chk("lit_mwe", 32'(memory_write_enable), 32'h1);
      chk("lit_maddr", memory_address, 32'h10);
      chk("lit_mout", memory_out, 32'h1234_5678);
      chk("lit_msize", 32'(memory_size), 32'h2);

      input_in = 32'h0000_A5C3;
      drive(32'h2000_0000, 1'b0, 2'd2, 2'd0, 32'h0);
      step();
      chk("lit_in_byte", data_out, 32'h0000_00C3);

      drive(32'h3000_0004, 1'b1, 2'd2, 2'd2, 32'hFF);
      step();
      chk("lit_owe", 32'(output_write_enable), 32'h1);
      chk("lit_oaddr", output_address, 32'h4);
      output_in = 32'hFF;
      drive(32'h3000_0004, 1'b0, 2'd2, 2'd2, 32'h0);
      step();
      chk("lit_out_rd", data_out, 32'hFF);

      drive(32'h0000_0000, 1'b1, 2'd2, 2'd2, 32'h1);
      step();
      chk("lit_f1_mwe", 32'(memory_write_enable), 32'h0);
      chk("lit_f1_do", data_out, 32'h0);
      chk("lit_f1_err", 32'(memory_error), 32'h1);
      pulse_rst();
      memory_in = 32'h5555_AAAA;
      drive(32'h1000_0002, 1'b0, 2'd0, 2'd2, 32'h0);
      step();
      chk("lit_f2_do", data_out, 32'h0);
      chk("lit_f2_err", 32'(memory_error), 32'h1);
      pulse_rst();
      drive(32'h4000_0000, 1'b0, 2'd0, 2'd2, 32'h0);
      step();
      chk("lit_f3_do", data_out, 32'h0);
      chk("lit_f3_err", 32'(memory_error), 32'h1);
      drive(32'h5000_0000, 1'b0, 2'd0, 2'd2, 32'h0);
      step();
      drive(32'h1000_0000, 1'b0, 2'd0, 2'd2, 32'h0);
      step();
      chk("lit_sticky", 32'(memory_error), 32'h1);
`ifdef MEMCTRL_FAULT_ADDR_EN
      chk("lit_fault_addr", fault_address, 32'h4000_0000);
`endif
      pulse_rst();
      step();
      chk("lit_after_rst", 32'(memory_error), 32'h0);

      for (int i = 0; i < 600; i++) begin
         rsel = int'($urandom_range(0, 5));
         if (rsel < 4) begin
            a = 32'(reg_base[rsel])
              + $urandom_range(0, 32'(reg_size[rsel]) + 3);
            if ($urandom_range(0, 9) == 0) a = 32'(reg_base[rsel]) - 1;
         end else begin
            a = $urandom;
         end
         drive(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), $urandom);
         if ($urandom_range(0, 3) != 0) begin
            data_in_size = 2'($urandom_range(0, 2));
            data_out_size = 2'($urandom_range(0, 2));
         end
         code_in = $urandom;
         memory_in = $urandom;
         input_in = $urandom;
         output_in = $urandom;
         if ($urandom_range(0, 39) == 0) set_rst(1'b0);
         else set_rst(1'b1);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
Address decoder and bus router between the processor core's single data/address bus and four targets: read-only code ROM, read/write data memory, read-only input port, and a read/write output map. The core connects to one side; each target gets its own address, data, size and write-enable signals. All routing is combinational. The only state is the access-fault flag, which is sticky.

Parameters:
CODE_BASE 32'h0000_0000 start of code region (read-only)
CODE_SIZE 32'h0001_0000 byte span of code region
MEM_BASE 32'h1000_0000 start of data memory region
MEM_SIZE 32'h0010_0000 byte span of data memory region
IN_BASE 32'h2000_0000 start of input region (read-only)
IN_SIZE 32'h0000_0010 byte span of input region
OUT_BASE 32'h3000_0000 start of output region
OUT_SIZE 32'h0000_0100 byte span of output region

Ports:
clk input 1 system clock; single clock domain, rising edge
rst input 1 asynchronous active-low reset
address input 32 core byte address
write_enable input 1 core write strobe
data_in_size input 2 size of write data: 00 byte, 01 half, 10 word, 11 reserved
data_out_size input 2 size of read data (same encoding)
data_in input 32 write data from core
data_out output 32 read data to core
memory_error output 1 sticky access-fault flag
code_in input 32 word fetched from code ROM at code_address
code_address output 32 offset into code region
memory_in input 32 read data from data memory
memory_address output 32 offset into data memory
memory_out output 32 write data to data memory
memory_size output 2 access size to data memory
memory_write_enable output 1 data memory write strobe
input_in input 32 input port value
output_in input 32 readback from output map
output_address output 32 offset into output region
output_out output 32 write data to output map
output_size output 2 access size to output map
output_write_enable output 1 output map write strobe

Behaviour:
- Region hit: BASE <= address < BASE+SIZE, compared as unsigned 32-bit. Regions do not overlap. No hit = unmapped.
- Offsets are always driven, whether or not the region is hit: code_address = address-CODE_BASE, memory_address = address-MEM_BASE, output_address = address-OUT_BASE.
- memory_out and output_out = data_in. memory_size and output_size = data_in_size when write_enable=1, else data_out_size.
- Write strobes are combinational:
  - memory_write_enable = write_enable & mem hit & no fault.
  - output_write_enable = write_enable & out hit & no fault.
  - All other strobes are 0.
- Read mux (combinational, zero latency) selects by region: code_in, memory_in, input_in or output_in. Unmapped returns 0.
- The selected read value is zero-extended per data_out_size: byte keeps [7:0], half keeps [15:0], word keeps all 32 bits.
- Fault conditions, evaluated every cycle (size = data_in_size on write, data_out_size on read):
  - unmapped address;
  - size 11;
  - half access with address[0]=1;
  - word access with address[1:0]!=0;
  - write to the code or input region.
- A faulting cycle suppresses both write strobes and forces data_out=0.
- memory_error:
  - reset value 0;
  - set on the first rising clk edge where a fault is present;
  - remains 1 until rst is asserted; never cleared by a later good access.
- Reset asserted mid-operation clears memory_error immediately (asynchronous). Combinational paths stay active during reset, but both write strobes are forced to 0 while rst=0.

Optional Feature:
MEMCTRL_FAULT_ADDR_EN
- Defined: adds output fault_address[31:0]. Reset value 0. Loads address on the same edge that first sets memory_error; holds thereafter until reset.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 -> memory_error=0, both write strobes 0. Release rst; word read at 0x0000_0004 with code_in=32'hDEADBEEF -> data_out=32'hDEADBEEF, code_address=4, memory_error stays 0.
- Word write 0x1000_0010, data_in=32'h12345678 -> memory_write_enable=1, memory_address=0x10, memory_out=32'h12345678, memory_size=10.
- Byte read 0x2000_0000, input_in=32'h0000_A5C3, data_out_size=00 -> data_out=32'h0000_00C3.
- Write 0x3000_0004, data_in=32'hFF -> output_write_enable=1, output_address=4. Then read back with output_in=32'hFF -> data_out=32'hFF.
- Fault cases: write to 0x0000_0000; word read at 0x1000_0002; read at 0x4000_0000 -> no strobe, data_out=0, memory_error=1 after the next clk edge. Following good access -> memory_error still 1. Pulse rst low -> memory_error=0.
- MEMCTRL_FAULT_ADDR_EN defined: first fault at 0x4000_0000, second at 0x5000_0000 -> fault_address=32'h4000_0000.
